// File: rtl/hazard_pkg.sv
// Shared scoreboard record, constants and parameter legality check for pipe_hazard_unit.
package hazard_pkg;

  localparam int unsigned RW_MAX   = 8;
  localparam int unsigned FWD_NONE = 0;

  typedef struct packed {
    logic              valid;
    logic [RW_MAX-1:0] rd;
    logic              regwrite;
    logic              is_load;
    logic [RW_MAX-1:0] rs1;
    logic [RW_MAX-1:0] rs2;
    logic              rs1_used;
    logic              rs2_used;
  } sb_entry_t;

  function automatic bit params_legal(input int unsigned depth, input int unsigned reg_w,
                                      input int unsigned load_lat, input int unsigned br_stage,
                                      input int unsigned fwd_w);
    return (depth >= 2) && (depth <= 8) && (reg_w >= 1) && (reg_w <= RW_MAX) &&
           (load_lat >= 1) && (load_lat + 2 <= depth) && (br_stage + 2 <= depth) &&
           ((1 << fwd_w) >= depth);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_fwd_select.sv
// Priority forward-select for one EX operand: youngest qualifying entry 1..DEPTH-1 wins.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned FWD_W    = $clog2(DEPTH)
) (
  input  sb_entry_t         entries [DEPTH],
  input  logic              src_used,
  input  logic [RW_MAX-1:0] src,
  output logic [FWD_W-1:0]  sel
);

  // Scan oldest to youngest so the lowest matching index is the last one written.
  always_comb begin
    sel = FWD_W'(FWD_NONE);
    if (entries[0].valid && src_used && (src != '0)) begin
      for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
        if (entries[k].valid && entries[k].regwrite && (entries[k].rd == src) &&
            (!entries[k].is_load || (k >= 1 + LOAD_LAT)))
          sel = FWD_W'(k);
      end
    end
  end

  logic unused_fields;
  always_comb begin
    unused_fields = ^{entries[0].rd, entries[0].regwrite, entries[0].is_load};
    for (int unsigned k = 0; k < DEPTH; k++)
      unused_fields ^= ^{entries[k].rs1, entries[k].rs2, entries[k].rs1_used, entries[k].rs2_used};
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Scoreboard hazard/forward/flush controller for the in-order pipeline.
// Define HAZARD_STATS_EN to add saturating stall/redirect/forward counters.
module pipe_hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned BR_STAGE = 1,
  parameter int unsigned FWD_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_is_load,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stat_stall,
  output logic [31:0]      stat_flush,
  output logic [31:0]      stat_fwd
`endif
);

  if (!params_legal(DEPTH, REG_W, LOAD_LAT, BR_STAGE, FWD_W)) begin : g_bad_params
    $error("pipe_hazard_unit: illegal parameter combination");
  end

  sb_entry_t sb [DEPTH];
  sb_entry_t id_rec;
  logic      advance, redirect, load_hit, stall;

  always_comb begin
    id_rec          = '0;
    id_rec.valid    = id_valid;
    id_rec.rd       = RW_MAX'(id_rd);
    id_rec.regwrite = id_regwrite;
    id_rec.is_load  = id_is_load;
    id_rec.rs1      = RW_MAX'(id_rs1);
    id_rec.rs2      = RW_MAX'(id_rs2);
    id_rec.rs1_used = id_rs1_used;
    id_rec.rs2_used = id_rs2_used;
  end

  // Loads still younger than LOAD_LAT cannot supply data to the instruction in ID.
  always_comb begin
    load_hit = 1'b0;
    for (int unsigned j = 0; j < LOAD_LAT; j++) begin
      if (sb[j].valid && sb[j].regwrite && sb[j].is_load &&
          ((id_rec.rs1_used && (id_rec.rs1 != '0) && (id_rec.rs1 == sb[j].rd)) ||
           (id_rec.rs2_used && (id_rec.rs2 != '0) && (id_rec.rs2 == sb[j].rd))))
        load_hit = 1'b1;
    end
  end

  always_comb begin
    advance     = !mem_busy;
    redirect    = advance && br_taken;
    stall       = advance && id_valid && load_hit && !redirect;
    pc_en       = rst && advance && !stall;
    ifid_en     = rst && advance && !stall;
    ifid_flush  = rst && redirect;
    idex_bubble = rst && (redirect || stall);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) sb[k] <= '0;
    end else if (advance) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        sb[k] <= sb[k-1];
        if (redirect && (k <= BR_STAGE)) sb[k].valid <= 1'b0;
      end
      sb[0] <= (id_valid && !stall && !redirect) ? id_rec : '0;
    end
  end

  fwd_select #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FWD_W(FWD_W)) u_fwd_a (
    .entries (sb),
    .src_used(sb[0].rs1_used),
    .src     (sb[0].rs1),
    .sel     (fwd_a)
  );

  fwd_select #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FWD_W(FWD_W)) u_fwd_b (
    .entries (sb),
    .src_used(sb[0].rs2_used),
    .src     (sb[0].rs2),
    .sel     (fwd_b)
  );

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_stall <= '0;
      stat_flush <= '0;
      stat_fwd   <= '0;
    end else begin
      if (stall && (stat_stall != '1)) stat_stall <= stat_stall + 32'd1;
      if (redirect && (stat_flush != '1)) stat_flush <= stat_flush + 32'd1;
      if (((fwd_a != '0) || (fwd_b != '0)) && (stat_fwd != '1)) stat_fwd <= stat_fwd + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed vector tables, reset corner cases,
// and randomized traffic against an in-flight-instruction list model.
module tb_pipe_hazard_unit;

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rw, ld, br, busy;
  } in_t;

  typedef struct {
    in_t        i;
    logic       pc, ie, fl, bu;
    logic [1:0] fa, fb;
  } vec_t;

  typedef struct {
    int rd; bit rw, ld; int rs1, rs2; bit u1, u2; int stage;
  } minst_t;

  localparam int M_DEPTH = 3;
  localparam int M_LL    = 1;
  localparam int M_BR    = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  in_t mi, bi;
  logic m_pc, m_ie, m_fl, m_bu, b_pc, b_ie, b_fl, b_bu;
  logic [1:0] m_fa, m_fb, b_fa, b_fb;
`ifdef HAZARD_STATS_EN
  logic [31:0] m_ss, m_sf, m_sw, b_ss, b_sf, b_sw;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  vec_t   tbl[$];
  vec_t   tbl2[$];
  minst_t mq[$];

  pipe_hazard_unit #(.DEPTH(3), .REG_W(5), .LOAD_LAT(1), .BR_STAGE(1)) dut (
    .clk(clk), .rst(rst), .id_valid(mi.v), .id_rs1(mi.rs1), .id_rs2(mi.rs2),
    .id_rs1_used(mi.u1), .id_rs2_used(mi.u2), .id_rd(mi.rd), .id_regwrite(mi.rw),
    .id_is_load(mi.ld), .br_taken(mi.br), .mem_busy(mi.busy), .pc_en(m_pc),
    .ifid_en(m_ie), .ifid_flush(m_fl), .idex_bubble(m_bu), .fwd_a(m_fa), .fwd_b(m_fb)
`ifdef HAZARD_STATS_EN
    , .stat_stall(m_ss), .stat_flush(m_sf), .stat_fwd(m_sw)
`endif
  );

  pipe_hazard_unit #(.DEPTH(4), .REG_W(5), .LOAD_LAT(2), .BR_STAGE(1)) dut4 (
    .clk(clk), .rst(rst), .id_valid(bi.v), .id_rs1(bi.rs1), .id_rs2(bi.rs2),
    .id_rs1_used(bi.u1), .id_rs2_used(bi.u2), .id_rd(bi.rd), .id_regwrite(bi.rw),
    .id_is_load(bi.ld), .br_taken(bi.br), .mem_busy(bi.busy), .pc_en(b_pc),
    .ifid_en(b_ie), .ifid_flush(b_fl), .idex_bubble(b_bu), .fwd_a(b_fa), .fwd_b(b_fb)
`ifdef HAZARD_STATS_EN
    , .stat_stall(b_ss), .stat_flush(b_sf), .stat_fwd(b_sw)
`endif
  );

  function automatic in_t I(int v, int rs1, int rs2, int u1, int u2, int rd,
                            int rw, int ld, int br, int busy);
    in_t r;
    r.v = 1'(v); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = 1'(u1); r.u2 = 1'(u2);
    r.rd = 5'(rd); r.rw = 1'(rw); r.ld = 1'(ld); r.br = 1'(br); r.busy = 1'(busy);
    return r;
  endfunction

  function automatic vec_t V(in_t i, int pc, int ie, int fl, int bu, int fa, int fb);
    vec_t r;
    r.i = i; r.pc = 1'(pc); r.ie = 1'(ie); r.fl = 1'(fl); r.bu = 1'(bu);
    r.fa = 2'(fa); r.fb = 2'(fb);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] act, input vec_t e);
    chk({tag, ".pc_en"},       32'(act[7]),   32'(e.pc));
    chk({tag, ".ifid_en"},     32'(act[6]),   32'(e.ie));
    chk({tag, ".ifid_flush"},  32'(act[5]),   32'(e.fl));
    chk({tag, ".idex_bubble"}, 32'(act[4]),   32'(e.bu));
    chk({tag, ".fwd_a"},       32'(act[3:2]), 32'(e.fa));
    chk({tag, ".fwd_b"},       32'(act[1:0]), 32'(e.fb));
  endtask

  // Reference model: a list of in-flight instructions tagged with their stage number.
  function automatic bit m_load_hit();
    foreach (mq[n])
      if (mq[n].stage < M_LL && mq[n].ld && mq[n].rw && mq[n].rd != 0 &&
          ((mi.u1 && int'(mi.rs1) == mq[n].rd) || (mi.u2 && int'(mi.rs2) == mq[n].rd)))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_fwd(int src, bit used);
    int best = 0;
    int best_stage = 1000;
    if (!used || src == 0) return 0;
    foreach (mq[n])
      if (mq[n].stage >= 1 && mq[n].rw && mq[n].rd == src &&
          (!mq[n].ld || mq[n].stage >= 1 + M_LL) && mq[n].stage < best_stage) begin
        best_stage = mq[n].stage;
        best = mq[n].stage;
      end
    return best;
  endfunction

  function automatic logic [7:0] m_expect();
    bit adv, redir, stall;
    int fa = 0;
    int fb = 0;
    adv   = !mi.busy;
    redir = adv && mi.br;
    stall = adv && mi.v && m_load_hit() && !redir;
    foreach (mq[n])
      if (mq[n].stage == 0) begin
        fa = m_fwd(mq[n].rs1, mq[n].u1);
        fb = m_fwd(mq[n].rs2, mq[n].u2);
      end
    return {adv && !stall, adv && !stall, redir, redir || stall, 2'(fa), 2'(fb)};
  endfunction

  task automatic m_clock();
    minst_t nq[$];
    minst_t x;
    bit redir, stall;
    if (mi.busy) return;
    redir = mi.br;
    stall = mi.v && m_load_hit() && !redir;
    foreach (mq[n]) begin
      x = mq[n];
      x.stage++;
      if (x.stage < M_DEPTH && !(redir && x.stage <= M_BR)) nq.push_back(x);
    end
    if (mi.v && !stall && !redir) begin
      x.rd = mi.rd; x.rw = mi.rw; x.ld = mi.ld; x.rs1 = mi.rs1; x.rs2 = mi.rs2;
      x.u1 = mi.u1; x.u2 = mi.u2; x.stage = 0;
      nq.push_back(x);
    end
    mq = nq;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // DEPTH=3, LOAD_LAT=1, BR_STAGE=1 directed sequence (v rs1 rs2 u1 u2 rd rw ld br busy)
    tbl.push_back(V(I(1, 1, 2,1,1, 5,1,0,0,0), 1,1,0,0,0,0)); // add x5
    tbl.push_back(V(I(1, 5, 1,1,1, 6,1,0,0,0), 1,1,0,0,0,0)); // sub x6,x5,x1
    tbl.push_back(V(I(0, 0, 0,0,0, 0,0,0,0,0), 1,1,0,0,1,0)); // sub in EX: fwd_a=1
    tbl.push_back(V(I(1, 3, 4,1,1, 5,1,0,0,0), 1,1,0,0,0,0)); // add x5
    tbl.push_back(V(I(1,10,11,1,1, 9,1,0,0,0), 1,1,0,0,0,0)); // or x9 (intervening)
    tbl.push_back(V(I(1, 5, 9,1,1, 6,1,0,0,0), 1,1,0,0,0,0)); // sub x6,x5,x9
    tbl.push_back(V(I(1, 1, 2,1,1, 5,1,0,0,0), 1,1,0,0,2,1)); // fwd_a=2, fwd_b=1
    tbl.push_back(V(I(1, 1, 2,1,1, 5,1,0,0,0), 1,1,0,0,0,0)); // second x5 writer
    tbl.push_back(V(I(1, 5, 5,1,1, 7,1,0,0,0), 1,1,0,0,0,0)); // sub x7,x5,x5
    tbl.push_back(V(I(0, 0, 0,0,0, 0,0,0,0,0), 1,1,0,0,1,1)); // youngest writer wins
    tbl.push_back(V(I(1, 2, 0,1,0, 7,1,1,0,0), 1,1,0,0,0,0)); // lw x7
    tbl.push_back(V(I(1, 7, 7,1,1, 8,1,0,0,0), 0,0,0,1,0,0)); // add x8,x7,x7: stall
    tbl.push_back(V(I(1, 7, 7,1,1, 8,1,0,0,0), 1,1,0,0,0,0)); // reissued
    tbl.push_back(V(I(0, 0, 0,0,0, 0,0,0,0,0), 1,1,0,0,2,2)); // load data from entry 2
    tbl.push_back(V(I(1, 1, 2,1,1, 0,0,0,0,0), 1,1,0,0,0,0)); // branch
    tbl.push_back(V(I(1, 1, 2,1,1, 3,1,0,0,0), 1,1,0,0,0,0)); // add x3 behind branch
    tbl.push_back(V(I(1, 1, 2,1,1, 4,1,0,1,0), 1,1,1,1,0,0)); // taken at MEM
    tbl.push_back(V(I(1, 3, 4,1,1,10,1,0,0,0), 1,1,0,0,0,0)); // reads x3
    tbl.push_back(V(I(0, 0, 0,0,0, 0,0,0,0,0), 1,1,0,0,0,0)); // flushed x3 not forwarded
    tbl.push_back(V(I(1, 2, 0,1,0, 7,1,1,0,0), 1,1,0,0,0,0)); // lw x7
    tbl.push_back(V(I(1, 7, 1,1,1, 8,1,0,1,1), 0,0,0,0,0,0)); // busy + hazard + branch
    tbl.push_back(V(I(1, 7, 1,1,1, 8,1,0,1,1), 0,0,0,0,0,0));
    tbl.push_back(V(I(1, 7, 1,1,1, 8,1,0,1,1), 0,0,0,0,0,0));
    tbl.push_back(V(I(1, 7, 1,1,1, 8,1,0,1,0), 1,1,1,1,0,0)); // redirect beats stall
    tbl.push_back(V(I(0, 0, 0,0,0, 0,0,0,0,0), 1,1,0,0,0,0));
    tbl.push_back(V(I(1, 1, 0,1,0, 0,1,0,0,0), 1,1,0,0,0,0)); // addi x0
    tbl.push_back(V(I(1, 0, 2,1,1, 1,1,0,0,0), 1,1,0,0,0,0)); // add x1,x0,x2
    tbl.push_back(V(I(1, 1, 0,1,0, 9,1,1,0,0), 1,1,0,0,0,0)); // lw x9; x0 never forwarded
    tbl.push_back(V(I(1, 1, 9,1,0,11,1,0,0,0), 1,1,0,0,1,0)); // unused rs2=x9: no stall
    tbl.push_back(V(I(0, 0, 0,0,0, 0,0,0,0,0), 1,1,0,0,2,0));

    // DEPTH=4, LOAD_LAT=2 load-use
    tbl2.push_back(V(I(1, 2, 0,1,0, 7,1,1,0,0), 1,1,0,0,0,0));
    tbl2.push_back(V(I(1, 7, 7,1,1, 8,1,0,0,0), 0,0,0,1,0,0));
    tbl2.push_back(V(I(1, 7, 7,1,1, 8,1,0,0,0), 0,0,0,1,0,0));
    tbl2.push_back(V(I(1, 7, 7,1,1, 8,1,0,0,0), 1,1,0,0,0,0));
    tbl2.push_back(V(I(0, 0, 0,0,0, 0,0,0,0,0), 1,1,0,0,3,3));

    mi = I(0,0,0,0,0,0,0,0,0,0);
    bi = mi;
    repeat (2) tick();

    // Outputs forced low while reset is held, even with hazard-like inputs.
    mi = I(1,7,7,1,1,8,1,0,1,0);
    #2;
    check_outs("in_reset", {m_pc, m_ie, m_fl, m_bu, m_fa, m_fb}, V(mi, 0,0,0,0,0,0));
    mi = I(0,0,0,0,0,0,0,0,0,0);
    rst = 1'b1;
    #1;
    check_outs("post_reset", {m_pc, m_ie, m_fl, m_bu, m_fa, m_fb}, V(mi, 1,1,0,0,0,0));
    tick();

    foreach (tbl2[n]) begin
      bi = tbl2[n].i;
      #2;
      check_outs($sformatf("d4_vec%0d", n), {b_pc, b_ie, b_fl, b_bu, b_fa, b_fb}, tbl2[n]);
      tick();
    end
    bi = I(0,0,0,0,0,0,0,0,0,0);
    repeat (4) tick();

    foreach (tbl[n]) begin
      mi = tbl[n].i;
      #2;
      check_outs($sformatf("vec%0d", n), {m_pc, m_ie, m_fl, m_bu, m_fa, m_fb}, tbl[n]);
      tick();
    end

    // Reset asserted mid-run with three live entries.
    mi = I(1, 1, 2,1,1, 5,1,0,0,0); tick();
    mi = I(1,10,11,1,1, 9,1,0,0,0); tick();
    mi = I(1, 5, 1,1,1, 6,1,0,0,0); tick();
    mi = I(1, 6, 0,1,0, 7,1,0,0,0);
    #1;
    chk("pre_reset.fwd_a", 32'(m_fa), 32'd2);
    rst = 1'b0;
    #1;
    check_outs("mid_reset", {m_pc, m_ie, m_fl, m_bu, m_fa, m_fb}, V(mi, 0,0,0,0,0,0));
    @(negedge clk);
    mi = I(0,0,0,0,0,0,0,0,0,0);
    rst = 1'b1;
    #1;
    check_outs("after_mid_reset", {m_pc, m_ie, m_fl, m_bu, m_fa, m_fb}, V(mi, 1,1,0,0,0,0));
    tick();

    mq.delete();
    for (int c = 0; c < 400; c++) begin
      mi = I($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
      #2;
      chk($sformatf("rand%0d {pc,ie,fl,bu,fa,fb}", c),
          32'({m_pc, m_ie, m_fl, m_bu, m_fa, m_fb}), 32'(m_expect()));
      @(posedge clk);
      m_clock();
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised scoreboard-based hazard, forwarding and flush controller for the in-order RISC-V pipeline.
- Replaces fixed two-source forwarding and single load-use detection with a tracked record of every in-flight instruction from EX to WB.
- Drives PC/IF-ID/ID-EX enables, bubble insertion, branch flushes and per-operand forward-mux selects.
- Also handles multi-cycle memory stalls.

Parameters:
- DEPTH, 3: scoreboard entries; entry 0 = EX, entry DEPTH-1 = WB; legal 2..8.
- REG_W, 5: register address width.
- LOAD_LAT, 1: stages after EX before load data is forwardable; legal 1..DEPTH-2.
- BR_STAGE, 1: entry index where branches resolve (0 = EX, 1 = MEM); legal 0..DEPTH-2.
- FWD_W, $clog2(DEPTH): forward-select width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  REG_W  ID source registers.
- id_rs1_used, id_rs2_used  in  1  source actually read.
- id_rd  in  REG_W  ID destination.
- id_regwrite  in  1  ID writes rd.
- id_is_load  in  1  ID is a load.
- br_taken  in  1  branch at entry BR_STAGE is taken.
- mem_busy  in  1  data memory not ready; freeze pipeline.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  load ID/EX with NOP controls.
- fwd_a, fwd_b  out  FWD_W  EX operand select: 0 = regfile/ID-EX value, k = result of entry k.

Behaviour:
- Entry record: valid, rd, regwrite, is_load, rs1, rs2, rs1_used, rs2_used. State is the entry array only.
- Reset (rst low, async): all entries valid=0. All outputs forced to 0 while rst is low. After release with no hazards: pc_en=1, ifid_en=1, others 0.
- advance = !mem_busy. When advance is 0, entries hold, pc_en=ifid_en=0, ifid_flush=idex_bubble=0, and br_taken is ignored. The branch source holds br_taken until accepted.
- Load-use stall: set when id_valid and a used source (nonzero) equals entry j rd, entry j is valid, regwrite and is_load, and j < LOAD_LAT. It gives pc_en=0, ifid_en=0, idex_bubble=1.
- Redirect: br_taken && advance gives ifid_flush=1, idex_bubble=1, pc_en=1, ifid_en=1. Redirect overrides load-use stall.
- Shift on advance: entry[k] <= entry[k-1] for k>=1.
  - New entries 1..BR_STAGE are invalidated on redirect, since they are younger than the branch.
  - entry[0] <= ID record if id_valid && !stall && !redirect, else bubble (valid=0).
- Forwarding (combinational from entry 0):
  - For each used, nonzero source, scan k=1..DEPTH-1; the lowest k wins.
  - Qualifying entry: valid, regwrite, rd match, and (!is_load or k >= 1+LOAD_LAT).
  - No match, x0, or entry 0 invalid gives 0.
- x0 as rd never causes a stall or a forward.
- Latency: stall/flush/select outputs are combinational from state and current inputs; the scoreboard updates on the next rising edge.

Optional Feature:
- Macro HAZARD_STATS_EN.
- With the macro defined, the block adds:
  - Output ports stat_stall, stat_flush, stat_fwd (32 bits each).
  - Counters for load-use stall cycles, accepted redirects, and cycles with fwd_a or fwd_b nonzero.
  - Each counter saturates at all-ones and resets to 0.
- Without it, no counters and no extra ports.

Decomposition:
- Package hazard_pkg holds:
  - sb_entry_t struct.
  - FWD_NONE = 0 constant.
  - Parameter legality-check function.
- One sub-module fwd_select: priority match of one source against entries 1..DEPTH-1, instantiated twice (a, b).

Test Plan:
- Reset mid-run: drive rst low with 3 valid entries → entries cleared and all outputs 0 immediately; after release, pc_en=1 and fwd_a=0.
- Back-to-back ALU, DEPTH=3:
  - "add x5" then "sub x6,x5,x1": in EX, fwd_a=1.
  - With one intervening instruction, fwd_a=2.
  - Both x5 writers in flight: fwd_a=1 (youngest wins).
- Load-use:
  - "lw x7" then "add x8,x7,x7": one cycle pc_en=0, ifid_en=0, idex_bubble=1; next cycle fwd_a=fwd_b=2.
  - LOAD_LAT=2, DEPTH=4: two stall cycles, then fwd_a=3.
- Branch, BR_STAGE=1: br_taken=1 → ifid_flush=1, idex_bubble=1; next cycle entries 0..1 valid=0, branch entry at index 2.
- mem_busy=1 for 3 cycles with a load-use pending and br_taken=1 → entries unchanged, pc_en=0, no flush; on release, redirect wins and the stall is suppressed.
- x0 and unused sources: "addi x0" then "add x1,x0,x2" → fwd_a=0, no stall; with id_rs2_used=0 and a matching load rd, no stall.
